// File: rtl/ibex_compressed_encoder_pkg.sv
// Shared constants, packing-state type and small helpers for the RV32 -> RVC encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ibex_compressed_encoder_pkg;

    // Major opcodes that have a compressed counterpart
    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_CHERI  = 7'h5b;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [15:0] C_EBREAK     = 16'h9002;

    // Filler halfword used to complete a word on flush
    localparam logic [15:0] C_NOP = 16'h0001;

    typedef enum logic {
        PACK_EMPTY = 1'b0,
        PACK_HALF  = 1'b1
    } pack_state_e;

    // x8..x15 are reachable through the 3-bit register fields
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

    // 12-bit immediate representable as a sign-extended 6-bit value
    function automatic logic fits_simm6(input logic [11:0] imm);
        return imm[11:5] == {7{imm[5]}};
    endfunction

endpackage

// File: rtl/ibex_compressed_encoder_if.sv
// Handshake bundle between an instruction producer/consumer and the encoder.
// Latency: n/a (wires only).
// Backpressure: in_ready_o / out_ready_i carry the valid-ready flow control.
// Ports: cheri_pmode_i mode select; in_* instruction input; flush_i pad request;
//        out_* packed word output; err_o malformed-input pulse; idle_o quiescent flag.
interface ibex_compressed_encoder_if;
    logic        cheri_pmode_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_instr_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_word_o;
    logic        err_o;
    logic        idle_o;

    // Encoder side
    modport slave (
        input  cheri_pmode_i, in_valid_i, in_instr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_word_o, err_o, idle_o
    );

    // Producer / consumer side
    modport master (
        output cheri_pmode_i, in_valid_i, in_instr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_word_o, err_o, idle_o
    );
endinterface

// File: rtl/ibex_compressed_encoder_rvc_compress.sv
// Combinational RV32 -> RVC/CHERIoT encode table: is_c_o set when instr_c_o expands back exactly.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated on whatever instruction is presented.
// Ports: instr_i 32-bit source, cheri_pmode_i mode, is_c_o compressible flag, instr_c_o 16-bit form.
module ibex_rvc_compress
    import ibex_compressed_encoder_pkg::*;
#(
    parameter bit CHERIoTEn  = 1'b1,
    parameter bit CompressEn = 1'b1
) (
    input  logic [31:0] instr_i,
    input  logic        cheri_pmode_i,
    output logic        is_c_o,
    output logic [15:0] instr_c_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i, imm_s;
    logic        cheri;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign imm_i  = instr_i[31:20];
    assign imm_s  = {instr_i[31:25], instr_i[11:7]};
    assign cheri  = CHERIoTEn & cheri_pmode_i;

    // Stack-pointer adjust forms share one slot between addi and cincoffsetimm
    logic        sp16_ok, spn_ok;
    logic [15:0] sp16_h, spn_h;

    assign sp16_ok = (rd == 5'd2) && (rs1 == 5'd2) && (imm_i != 12'd0) &&
                     (imm_i[3:0] == 4'd0) && (imm_i[11:9] == {3{imm_i[9]}});
    assign sp16_h  = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};

    assign spn_ok  = (rs1 == 5'd2) && is_creg(rd) && (imm_i != 12'd0) &&
                     (imm_i[1:0] == 2'd0) && (imm_i[11:10] == 2'd0);
    assign spn_h   = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};

    logic        c_ok;
    logic [15:0] c_h;

    always_comb begin
        c_ok = 1'b0;
        c_h  = 16'h0000;
        case (opcode)
            OPCODE_OP_IMM: begin
                case (funct3)
                    3'b000: begin
                        // c.addi16sp before c.addi; in pure-cap mode sp is a capability and
                        // both stack forms decode as cincoffsetimm instead.
                        if (!cheri && sp16_ok) begin
                            c_ok = 1'b1;
                            c_h  = sp16_h;
                        end else if ((rd == rs1) && (rd != 5'd0) && fits_simm6(imm_i) &&
                                     !(cheri && (rd == 5'd2))) begin
                            c_ok = 1'b1;
                            c_h  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                        end else if (!cheri && spn_ok) begin
                            c_ok = 1'b1;
                            c_h  = spn_h;
                        end else if ((rs1 == 5'd0) && (rd != 5'd0) && fits_simm6(imm_i)) begin
                            c_ok = 1'b1;
                            c_h  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                        end
                    end
                    3'b001: begin
                        if ((funct7 == 7'd0) && (rd == rs1) && (rd != 5'd0)) begin
                            c_ok = 1'b1;
                            c_h  = {3'b000, 1'b0, rd, rs2, 2'b10};
                        end
                    end
                    3'b101: begin
                        // funct7[5] distinguishes srai from srli
                        if ((rd == rs1) && is_creg(rd) &&
                            ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) begin
                            c_ok = 1'b1;
                            c_h  = {3'b100, 1'b0, 1'b0, funct7[5], rd[2:0], rs2, 2'b01};
                        end
                    end
                    3'b111: begin
                        if ((rd == rs1) && is_creg(rd) && fits_simm6(imm_i)) begin
                            c_ok = 1'b1;
                            c_h  = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
                        end
                    end
                    default: ;
                endcase
            end

            OPCODE_CHERI: begin
                // cincoffsetimm on csp takes over the addi16sp / addi4spn slots
                if (cheri && (funct3 == 3'b001)) begin
                    if (sp16_ok) begin
                        c_ok = 1'b1;
                        c_h  = sp16_h;
                    end else if (spn_ok) begin
                        c_ok = 1'b1;
                        c_h  = spn_h;
                    end
                end
            end

            OPCODE_LUI: begin
                // rd=sp is the addi16sp slot; zero immediate is reserved
                if ((rd != 5'd0) && (rd != 5'd2) && (instr_i[31:17] == {15{instr_i[17]}}) &&
                    (instr_i[17:12] != 6'd0)) begin
                    c_ok = 1'b1;
                    c_h  = {3'b011, instr_i[17], rd, instr_i[16:12], 2'b01};
                end
            end

            OPCODE_LOAD: begin
                if (funct3 == 3'b010) begin
                    if ((rs1 == 5'd2) && (rd != 5'd0) && (imm_i[11:8] == 4'd0) &&
                        (imm_i[1:0] == 2'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
                    end else if (is_creg(rd) && is_creg(rs1) && (imm_i[11:7] == 5'd0) &&
                                 (imm_i[1:0] == 2'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                    end
                end else if (cheri && (funct3 == 3'b011)) begin
                    // clc: 8-byte scaled offsets
                    if ((rs1 == 5'd2) && (rd != 5'd0) && (imm_i[11:9] == 3'd0) &&
                        (imm_i[2:0] == 3'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b011, imm_i[5], rd, imm_i[4:3], imm_i[8:6], 2'b10};
                    end else if (is_creg(rd) && is_creg(rs1) && (imm_i[11:8] == 4'd0) &&
                                 (imm_i[2:0] == 3'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b011, imm_i[5:3], rs1[2:0], imm_i[7:6], rd[2:0], 2'b00};
                    end
                end
            end

            OPCODE_STORE: begin
                if (funct3 == 3'b010) begin
                    if ((rs1 == 5'd2) && (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
                    end else if (is_creg(rs1) && is_creg(rs2) && (imm_s[11:7] == 5'd0) &&
                                 (imm_s[1:0] == 2'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                    end
                end else if (cheri && (funct3 == 3'b011)) begin
                    if ((rs1 == 5'd2) && (imm_s[11:9] == 3'd0) && (imm_s[2:0] == 3'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b111, imm_s[5:3], imm_s[8:6], rs2, 2'b10};
                    end else if (is_creg(rs1) && is_creg(rs2) && (imm_s[11:8] == 4'd0) &&
                                 (imm_s[2:0] == 3'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b111, imm_s[5:3], rs1[2:0], imm_s[7:6], rs2[2:0], 2'b00};
                    end
                end
            end

            OPCODE_OP: begin
                if ((funct7 == 7'd0) && (funct3 == 3'b000)) begin
                    if ((rs1 == 5'd0) && (rd != 5'd0) && (rs2 != 5'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b100, 1'b0, rd, rs2, 2'b10};
                    end else if ((rd == rs1) && (rd != 5'd0) && (rs2 != 5'd0)) begin
                        c_ok = 1'b1;
                        c_h  = {3'b100, 1'b1, rd, rs2, 2'b10};
                    end
                end else if ((rd == rs1) && is_creg(rd) && is_creg(rs2)) begin
                    if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
                        c_ok = 1'b1;
                        c_h  = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                    end else if (funct7 == 7'd0) begin
                        case (funct3)
                            3'b100: begin
                                c_ok = 1'b1;
                                c_h  = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
                            end
                            3'b110: begin
                                c_ok = 1'b1;
                                c_h  = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
                            end
                            3'b111: begin
                                c_ok = 1'b1;
                                c_h  = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
                            end
                            default: ;
                        endcase
                    end
                end
            end

            OPCODE_JALR: begin
                // Only the zero-offset, rd in {x0,x1} forms exist compressed
                if ((funct3 == 3'b000) && (imm_i == 12'd0) && (rs1 != 5'd0)) begin
                    if (rd == 5'd0) begin
                        c_ok = 1'b1;
                        c_h  = {3'b100, 1'b0, rs1, 5'd0, 2'b10};
                    end else if (rd == 5'd1) begin
                        c_ok = 1'b1;
                        c_h  = {3'b100, 1'b1, rs1, 5'd0, 2'b10};
                    end
                end
            end

            OPCODE_SYSTEM: begin
                if (instr_i == INSTR_EBREAK) begin
                    c_ok = 1'b1;
                    c_h  = C_EBREAK;
                end
            end

            // JAL and BRANCH are intentionally absent: repacking moves code, so
            // PC-relative offsets computed for the uncompressed image would be wrong.
            default: ;
        endcase
    end

    assign is_c_o    = CompressEn & c_ok;
    assign instr_c_o = c_h;

endmodule

// File: rtl/ibex_compressed_encoder.sv
// Streaming RV32 -> RVC compressor packing 16/32-bit parcels into little-endian 32-bit words.
// Latency: out_valid_o rises the cycle after the accept (or flush) that completes a word.
// Backpressure: in_ready_o = !out_valid_o | out_ready_i; a held output word stalls input.
// Ports: clk_i, rst_i (sync, active-high); bus (slave modport) carries input, flush,
//        output word, err_o pulse and idle_o.
module ibex_compressed_encoder
    import ibex_compressed_encoder_pkg::*;
#(
    parameter bit CHERIoTEn  = 1'b1,
    parameter bit CompressEn = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ibex_compressed_encoder_if.slave    bus
);

    logic        is_c;
    logic [15:0] instr_c;

    ibex_rvc_compress #(
        .CHERIoTEn  (CHERIoTEn),
        .CompressEn (CompressEn)
    ) u_compress (
        .instr_i       (bus.in_instr_i),
        .cheri_pmode_i (bus.cheri_pmode_i),
        .is_c_o        (is_c),
        .instr_c_o     (instr_c)
    );

    pack_state_e state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_word_q, out_word_d;
    logic        err_q, err_d;

    logic in_ready;
    logic accept;
    logic flush_take;
    logic legal;

    // Any accept either finds the output register empty or retires it in the same cycle
    assign in_ready   = !out_valid_q | bus.out_ready_i;
    assign accept     = bus.in_valid_i & in_ready;
    assign flush_take = bus.flush_i & in_ready & !bus.in_valid_i;
    assign legal      = bus.in_instr_i[1:0] == 2'b11;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q & !bus.out_ready_i;
        out_word_d  = out_word_q;
        err_d       = 1'b0;

        if (accept) begin
            if (!legal) begin
                // Dropped; packing state is left as it was
                err_d = 1'b1;
            end else if (is_c) begin
                if (state_q == PACK_EMPTY) begin
                    state_d = PACK_HALF;
                    pend_d  = instr_c;
                end else begin
                    state_d     = PACK_EMPTY;
                    out_valid_d = 1'b1;
                    out_word_d  = {instr_c, pend_q};
                end
            end else begin
                out_valid_d = 1'b1;
                if (state_q == PACK_EMPTY) begin
                    out_word_d = bus.in_instr_i;
                end else begin
                    // A 32-bit parcel straddles the word boundary; its upper half stays pending
                    out_word_d = {bus.in_instr_i[15:0], pend_q};
                    pend_d     = bus.in_instr_i[31:16];
                end
            end
        end else if (flush_take && (state_q == PACK_HALF)) begin
            state_d     = PACK_EMPTY;
            out_valid_d = 1'b1;
            out_word_d  = {C_NOP, pend_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= PACK_EMPTY;
            pend_q      <= 16'h0000;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_word_o  = out_word_q;
    assign bus.err_o       = err_q;
    assign bus.idle_o      = (state_q == PACK_EMPTY) && !out_valid_q;

endmodule

// File: doc/ibex_compressed_encoder.md
Name: ibex_compressed_encoder

Overview:
- Streaming RV32 → RVC compressor and halfword packer; the inverse direction of the compressed-instruction decode path.
- Accepts 32-bit instructions one per handshake and replaces each with its 16-bit RVC/CHERIoT-compressed form where legal.
- Packs the resulting 16/32-bit parcels into halfword-aligned little-endian 32-bit words.
- Used in the code-generation/self-test path to build compressed instruction images fed back into the fetch path.

Parameters:
- CHERIoTEn, 1'b1, enables CHERIoT capability forms (c.clc/c.csc/c.clcsp/c.cscsp, c.incaddr4cspn, c.incaddr16csp) when cheri_pmode_i=1.
- CompressEn, 1'b1, 0: never compress; block degenerates to a registered pass-through.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- cheri_pmode_i  in  1  CHERI pure-capability mode; must be stable while block not idle
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  instruction accepted when in_valid_i & in_ready_o
- in_instr_i  in  32  uncompressed instruction
- flush_i  in  1  request to emit any pending halfword padded with c.nop; shares in_ready_o
- out_valid_o  out  1  packed word valid
- out_ready_i  in  1  downstream ready
- out_word_o  out  32  packed word; bits[15:0] = lower address
- err_o  out  1  one-cycle pulse: accepted instr_i[1:0]!=2'b11; instruction dropped
- idle_o  out  1  no pending halfword and no valid output

Behaviour:
- Reset: out_valid_o=0, out_word_o=0, err_o=0, pending halfword empty, idle_o=1. Reset mid-stream discards pending and output without emission.
- in_ready_o = !out_valid_o | out_ready_i; it is combinational from out_ready_i only, never from in_valid_i.
- Compression rule: emit 16-bit h iff decompressing h with the same CHERIoTEn/cheri_pmode_i yields exactly in_instr_i and is not illegal. Otherwise pass the 32-bit word unchanged.
- Exclusions, never compressed: JAL, all BRANCH (offsets are invalid after repacking), hint forms with rd=x0, c.nop.
- JALR with imm=0 (c.jr/c.jalr) and ebreak are compressed.
- cheri_pmode_i=1 with CHERIoTEn: addi rd',sp / addi sp,sp are not compressed (slots are cincoffsetimm); the cincoffsetimm equivalents are compressed instead.
- Packing state machine on accept:
  - EMPTY, 16-bit h → HALF(P=h); no output.
  - EMPTY, 32-bit w → output w; stays EMPTY.
  - HALF(P), 16-bit h → output {h,P} → EMPTY.
  - HALF(P), 32-bit w → output {w[15:0],P} → HALF(P=w[31:16]).
- Flush is taken when flush_i & in_ready_o & !in_valid_i. If in_valid_i=1 in the same cycle, the instruction wins and flush_i must be held.
  - HALF(P): output {16'h0001,P} → EMPTY.
  - EMPTY: no-op.
- Latency: out_valid_o rises the cycle after the completing accept. Output is held stable until out_ready_i.
- Accept with simultaneous out_ready_i: old word retires and new word loads in the same cycle, giving full throughput.
- Error input (low bits !=11): consumed, err_o pulses next cycle, state unchanged.
- CompressEn=0: every legal input produces one output word; pending is never used.

Decomposition:
- ibex_pkg gains C_NOP=16'h0001 and a typedef pack_state_e {PACK_EMPTY, PACK_HALF}; existing opcode constants are reused.
- Combinational sub-module ibex_rvc_compress (instr_i, cheri_pmode_i → is_c_o, instr_c_o[15:0]) holds the encode table. The packing FSM and output register stay in the top module.

Test Plan:
- pmode=0: addi x8,x8,1 (0x00140413) ×2 → single word 0x04050405; idle_o=1 afterwards.
- lui x5,0x12345 (0x123452B7), not compressible → 0x123452B7. Then addi x8,x8,1 followed by 0x123452B7 → 0x52B70405. Then flush → 0x00011234.
- jal x1,8 (0x008000EF) → passed through uncompressed as 0x008000EF despite a c.jal encoding existing.
- addi sp,sp,16 (0x01010113):
  - pmode=0, sent twice → 0x61416141.
  - pmode=1 → 0x01010113 uncompressed.
- Hold out_ready_i=0 for 3 cycles with a stream queued → in_ready_o=0, out_word_o stable, no loss or duplication. Assert rst_i while HALF → no word emitted, idle_o=1.
- in_instr_i=0x00000001 → err_o pulse, no output. Random-stimulus property: every compressed half in the output re-expands exactly to its source instruction.
